// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the program-counter sequencer: widths, reset
// vector, PC-operation and stack-command encodings, sequencer states.
package pc_sequencer_pkg;

  localparam int DEF_PC_WIDTH = 11;
  localparam logic [DEF_PC_WIDTH-1:0] RESET_VEC = 11'h7FF;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_GOTO   = 3'd1,
    OP_CALL   = 3'd2,
    OP_RETLW  = 3'd3,
    OP_PCL_WR = 3'd4,
    OP_SKIP   = 3'd5
  } pc_op_e;

  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10
  } stk_cmd_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Execute-stage to sequencer bundle: PC operation and operands in, fetch
// address, stack command and status out.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
);
  logic [2:0]          pc_op;
  logic [8:0]          k;
  logic [7:0]          pcl_data;
  logic [1:0]          pa;
  logic [PC_WIDTH-1:0] stack_top;
  logic [PC_WIDTH-1:0] pc;
  stk_cmd_e            stk_cmd;
  logic [PC_WIDTH-1:0] stk_data;
  logic                flush;
  logic                stk_overflow;
  logic                stk_underflow;

  modport master (
    output pc_op, k, pcl_data, pa, stack_top,
    input  pc, stk_cmd, stk_data, flush, stk_overflow, stk_underflow
  );

  modport slave (
    input  pc_op, k, pcl_data, pa, stack_top,
    output pc, stk_cmd, stk_data, flush, stk_overflow, stk_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Two-stage fetch/execute program-counter sequencer with return-stack
// command generation, depth tracking and sticky overflow/underflow flags.
//
//   state    | meaning
//   ST_RUN   | executing instruction normally, pc_op honoured
//   ST_FLUSH | instruction in execute is squashed, pc_op treated as INC
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] PC_RESET = {PC_WIDTH{1'b1}};

  seq_state_e          state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [1:0]          depth;
  logic                overflow, underflow;
  stk_cmd_e            stk_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FLUSH;
      pc    <= PC_RESET;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_RUN;
    pc_nxt    = pc + PC_ONE;
    stk_cmd   = STK_NOP;
    if (state == ST_RUN) begin
      case (pc_op_e'(bus.pc_op))
        OP_GOTO: begin
          pc_nxt    = PC_WIDTH'({bus.pa, bus.k});
          state_nxt = ST_FLUSH;
        end
        OP_CALL: begin
          pc_nxt    = PC_WIDTH'({bus.pa, 1'b0, bus.k[7:0]});
          stk_cmd   = STK_PUSH;
          state_nxt = ST_FLUSH;
        end
        OP_RETLW: begin
          pc_nxt    = bus.stack_top;
          stk_cmd   = STK_POP;
          state_nxt = ST_FLUSH;
        end
        OP_PCL_WR: begin
          pc_nxt    = PC_WIDTH'({bus.pa, 1'b0, bus.pcl_data});
          state_nxt = ST_FLUSH;
        end
        OP_SKIP: begin
          state_nxt = ST_FLUSH;
        end
        default: ;
      endcase
    end
    // The stack must never see a command while the core is held in reset.
    if (!rst_n) stk_cmd = STK_NOP;
  end

  // Overflowing push overwrites the oldest entry, so depth saturates at 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth     <= 2'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (stk_cmd)
        STK_PUSH: begin
          if (depth == 2'd2) overflow <= 1'b1;
          else               depth    <= depth + 2'd1;
        end
        STK_POP: begin
          if (depth == 2'd0) underflow <= 1'b1;
          else               depth     <= depth - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc            = pc;
  assign bus.stk_cmd       = stk_cmd;
  assign bus.stk_data      = pc;
  assign bus.flush         = (state == ST_FLUSH);
  assign bus.stk_overflow  = overflow;
  assign bus.stk_underflow = underflow;

endmodule
